// File: rtl/teclado_matricial_if.sv
// Keypad-side signal bundle: enable, matrix lines and the digit buffer handshake.
// The slave modport is the keypad front-end; the master modport drives it.
interface teclado_matricial_if;
    logic        teclado_en;
    logic [3:0]  col;
    logic [3:0]  lin;
    logic [79:0] digitos_value;
    logic        digitos_valid;

    modport master (
        output teclado_en,
        output col,
        input  lin,
        input  digitos_value,
        input  digitos_valid
    );

    modport slave (
        input  teclado_en,
        input  col,
        output lin,
        output digitos_value,
        output digitos_valid
    );
endinterface

// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner with debounce, feeding a 20-digit shift buffer.
// Buffer clears after '*' / '#', on inactivity timeout, and while disabled.
module teclado_matricial #(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    teclado_matricial_if.slave  kbd
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [79:0] EMPTY = {80{1'b1}};
    localparam logic [3:0]  NO_CODE = 4'hF;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    lin_q, lin_d;
    logic [79:0]   buf_q, buf_d;
    logic          valid_q, valid_d;
    logic          load;

    function automatic logic one_low(input logic [3:0] c);
        return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] c);
        case (c)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Letter keys (column 3) map to NO_CODE so they are debounced but never emitted.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        if (c == 2'd3) return NO_CODE;
        case (r)
            2'd0:    return 4'(c) + 4'd1;
            2'd1:    return 4'(c) + 4'd4;
            2'd2:    return 4'(c) + 4'd7;
            default: return (c == 2'd0) ? 4'hA : ((c == 2'd1) ? 4'h0 : 4'hB);
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        deb_d    = deb_q;
        to_d     = to_q;
        pat_d    = pat_q;
        code_d   = code_q;
        lin_d    = lin_q;
        buf_d    = buf_q;
        valid_d  = 1'b0;
        load     = 1'b0;

        if (!kbd.teclado_en) begin
            state_d  = SCAN;
            row_d    = 2'd0;
            settle_d = '0;
            deb_d    = '0;
            to_d     = '0;
            pat_d    = 4'hF;
            code_d   = NO_CODE;
            lin_d    = 4'hF;
            buf_d    = EMPTY;
        end else begin
            case (state_q)
                SCAN: begin
                    // Only count settle time once the row is actually being driven.
                    if (lin_q[row_q] == 1'b0) begin
                        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                            settle_d = '0;
                            if (one_low(kbd.col)) begin
                                pat_d   = kbd.col;
                                code_d  = key_code(row_q, low_index(kbd.col));
                                deb_d   = '0;
                                state_d = DEBOUNCE;
                            end else begin
                                row_d = row_q + 2'd1;
                            end
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (kbd.col == pat_q) begin
                        if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                            deb_d = '0;
                            if (code_q == NO_CODE) begin
                                state_d = RELEASE;
                            end else begin
                                state_d = EMIT;
                                load    = 1'b1;
                            end
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end else begin
                        deb_d    = '0;
                        settle_d = '0;
                        row_d    = row_q + 2'd1;
                        state_d  = SCAN;
                    end
                end
                EMIT: begin
                    state_d = RELEASE;
                end
                default: begin
                    if (kbd.col == 4'hF) begin
                        if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                            deb_d    = '0;
                            settle_d = '0;
                            row_d    = 2'd0;
                            state_d  = SCAN;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            endcase

            lin_d = ~(4'b0001 << row_d);

            // A new key always beats a coincident timeout.
            if (load) begin
                buf_d   = {buf_q[75:0], code_q};
                valid_d = 1'b1;
                to_d    = '0;
            end else if (state_q == EMIT) begin
                to_d = '0;
                if (code_q == 4'hA || code_q == 4'hB) buf_d = EMPTY;
            end else if (buf_q == EMPTY) begin
                to_d = '0;
            end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                buf_d = EMPTY;
                to_d  = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SCAN;
            row_q    <= 2'd0;
            settle_q <= '0;
            deb_q    <= '0;
            to_q     <= '0;
            pat_q    <= 4'hF;
            code_q   <= NO_CODE;
            lin_q    <= 4'hF;
            buf_q    <= EMPTY;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            deb_q    <= deb_d;
            to_q     <= to_d;
            pat_q    <= pat_d;
            code_q   <= code_d;
            lin_q    <= lin_d;
            buf_q    <= buf_d;
            valid_q  <= valid_d;
        end
    end

    assign kbd.lin           = lin_q;
    assign kbd.digitos_value = buf_q;
    assign kbd.digitos_valid = valid_q;
endmodule

// File: tb/tb_teclado_matricial.sv
// Bench for teclado_matricial: a keypad model driven by directed and random presses,
// checked against a digit-list reference model of the buffer.
module tb_teclado_matricial;
    localparam int T = 1000;
    localparam logic [79:0] EMPTY = {80{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    teclado_matricial_if bus ();

    teclado_matricial #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kbd(bus.slave)
    );

    // Keypad: a pressed key shorts its column low while its row is driven low.
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    always_comb begin
        bus.col = 4'hF;
        if (key_down && bus.lin[key_r] == 1'b0) bus.col = ~(4'b0001 << key_c);
    end

    // Key legend by row*4+col; -1 marks letter keys that never produce a digit.
    int keymap [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, 10, 0, 11, -1};

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [3:0] model_d [20];

    function automatic logic [79:0] model_value();
        logic [79:0] v;
        for (int i = 0; i < 20; i++) v[4*i +: 4] = model_d[i];
        return v;
    endfunction

    task automatic model_push(input int code);
        for (int i = 19; i > 0; i--) model_d[i] = model_d[i-1];
        model_d[0] = 4'(code);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 20; i++) model_d[i] = 4'hF;
    endtask

    int          pulses = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    logic [79:0] last_val = '0;
    logic [79:0] after_val = '0;
    logic        prev_valid = 1'b0;

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (!rst) begin
            if (prev_valid) after_val = bus.digitos_value;
            if (bus.digitos_valid) begin
                chk("no_back_to_back_valid", {79'd0, prev_valid}, 80'd0);
                pulses++;
                last_val = bus.digitos_value;
                last_pulse_cyc = cyc;
            end
        end
        prev_valid = bus.digitos_valid;
    end

    task automatic press(input int r, input int c, input int hold, input int gap);
        int p0;
        int code;
        logic [79:0] exp_at;
        code = keymap[r*4 + c];
        p0 = pulses;
        if (code >= 0) model_push(code);
        exp_at = model_value();
        key_r = 2'(r);
        key_c = 2'(c);
        key_down = 1'b1;
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (gap) @(negedge clk);
        chk("pulse_count", 80'(pulses - p0), (code >= 0) ? 80'd1 : 80'd0);
        if (code >= 0) chk("value_at_pulse", last_val, exp_at);
        if (code == 10 || code == 11) model_clear();
        chk("value_after_release", bus.digitos_value, model_value());
    endtask

    task automatic wait_lin(input logic [3:0] pattern, input string tag);
        int n;
        n = 0;
        while (bus.lin != pattern && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk(tag, {76'd0, bus.lin}, {76'd0, pattern});
    endtask

    initial begin
        int p0;
        int p1;
        int n;
        model_clear();
        bus.teclado_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_lin", {76'd0, bus.lin}, 80'hF);
        chk("reset_value", bus.digitos_value, EMPTY);
        chk("reset_valid", {79'd0, bus.digitos_valid}, 80'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.teclado_en = 1'b1;

        // Single key held long: one pulse only.
        press(1, 1, 20, 10);
        chk("key5_value", bus.digitos_value, {{76{1'b1}}, 4'h5});

        // 1..8 then '*'.
        for (int k = 0; k < 8; k++) press(k / 3, k % 3, 20, 10);
        press(3, 0, 20, 10);
        chk("star_low36", {44'd0, last_val[35:0]}, {44'd0, 36'h12345678A});
        chk("star_clears_next", after_val, EMPTY);

        // Wrap-around with 21 presses of '1'.
        p0 = pulses;
        for (int k = 0; k < 21; k++) begin
            press(0, 0, 20, 10);
            if (k == 19) chk("twenty_ones", bus.digitos_value, {20{4'h1}});
        end
        chk("twenty_one_ones", bus.digitos_value, {20{4'h1}});
        chk("twenty_one_pulses", 80'(pulses - p0), 80'd21);
        press(3, 2, 20, 10);

        // Short glitch on row 2 while it is being scanned.
        press(0, 2, 20, 10);
        p0 = pulses;
        key_r = 2'd2;
        key_c = 2'd0;
        wait_lin(4'b1011, "glitch_row_wait");
        key_down = 1'b1;
        repeat (2) @(negedge clk);
        key_down = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_no_pulse", 80'(pulses - p0), 80'd0);
        chk("glitch_value", bus.digitos_value, model_value());

        // Letter C: held in RELEASE on its row, nothing emitted.
        key_r = 2'd2;
        key_c = 2'd3;
        key_down = 1'b1;
        repeat (30) @(negedge clk);
        chk("letter_holds_row", {76'd0, bus.lin}, {76'd0, 4'b1011});
        key_down = 1'b0;
        repeat (10) @(negedge clk);
        chk("letter_no_pulse", 80'(pulses - p0), 80'd0);
        chk("letter_value", bus.digitos_value, model_value());
        press(3, 2, 20, 10);

        // Inactivity timeout.
        press(2, 2, 20, 10);
        p0 = pulses;
        p1 = last_pulse_cyc;
        while (cyc < p1 + T - 10) @(negedge clk);
        chk("before_timeout", bus.digitos_value, model_value());
        while (cyc < p1 + T + 10) @(negedge clk);
        model_clear();
        chk("after_timeout", bus.digitos_value, EMPTY);
        chk("timeout_no_pulse", 80'(pulses - p0), 80'd0);

        // A press shortly before the timeout restarts the counter.
        press(2, 2, 20, 10);
        p1 = last_pulse_cyc;
        while (cyc < p1 + T - 30) @(negedge clk);
        press(2, 2, 20, 10);
        chk("restart_value", bus.digitos_value, {{72{1'b1}}, 8'h99});
        p1 = last_pulse_cyc;
        while (cyc < p1 + T - 10) @(negedge clk);
        chk("restart_holds", bus.digitos_value, model_value());
        while (cyc < p1 + T + 10) @(negedge clk);
        model_clear();
        chk("restart_then_clears", bus.digitos_value, EMPTY);

        // Disable in the middle of debounce.
        press(0, 2, 20, 10);
        press(1, 0, 20, 10);
        p0 = pulses;
        key_r = 2'd1;
        key_c = 2'd2;
        key_down = 1'b1;
        @(negedge clk);
        wait_lin(4'b1101, "debounce_row_wait");
        repeat (2) @(negedge clk);
        bus.teclado_en = 1'b0;
        @(negedge clk);
        chk("disable_lin", {76'd0, bus.lin}, 80'hF);
        chk("disable_value", bus.digitos_value, EMPTY);
        chk("disable_valid", {79'd0, bus.digitos_valid}, 80'd0);
        model_clear();
        key_down = 1'b0;
        repeat (5) @(negedge clk);
        bus.teclado_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("disable_no_pulse", 80'(pulses - p0), 80'd0);

        // Reset during the EMIT cycle.
        key_r = 2'd2;
        key_c = 2'd0;
        key_down = 1'b1;
        n = 0;
        while (!bus.digitos_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("emit_seen", {79'd0, bus.digitos_valid}, 80'd1);
        rst = 1'b1;
        #1;
        chk("rst_lin", {76'd0, bus.lin}, 80'hF);
        chk("rst_value", bus.digitos_value, EMPTY);
        chk("rst_valid", {79'd0, bus.digitos_valid}, 80'd0);
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        press(3, 1, 20, 10);
        chk("zero_after_reset", bus.digitos_value, {{76{1'b1}}, 4'h0});

        // Random keys with occasional short glitches.
        for (int k = 0; k < 40; k++) begin
            int kk;
            if ($urandom_range(0, 3) == 0) begin
                p0 = pulses;
                kk = int'($urandom_range(0, 15));
                key_r = 2'(kk / 4);
                key_c = 2'(kk % 4);
                key_down = 1'b1;
                repeat (2) @(negedge clk);
                key_down = 1'b0;
                repeat (8) @(negedge clk);
                chk("rand_glitch_no_pulse", 80'(pulses - p0), 80'd0);
            end
            kk = int'($urandom_range(0, 15));
            press(kk / 4, kk % 4, int'($urandom_range(20, 40)), int'($urandom_range(8, 20)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/teclado_matricial.md
Name: teclado_matricial

Overview:
- Keypad front-end for the lock's operational core. It produces the `digitos_value` / `digitos_valid` pair that the operational block consumes.
- Scans a 4x4 matrix keypad and debounces each press.
- Shifts accepted keys into a 20-digit buffer and emits a one-cycle `digitos_valid` per accepted key.
- Clears the buffer after `*` or `#`, on inactivity timeout, and while disabled.

Parameters:
- SETTLE_CYCLES, 2, cycles a row is driven low before columns are sampled (>=1)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (>=1)
- TIMEOUT_CYCLES, 1000, idle cycles with a non-empty buffer before auto-clear (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- teclado_en  input  1  keypad enable from the operational block
- col  input  4  column sense lines, active-low, pulled up (4'b1111 = nothing pressed)
- lin  output  4  row drive lines, active-low (one-hot low while scanning)
- digitos_value  output  80  senhaPac_t; digits[i] = bits[4i+3:4i]; digits[0] = newest; 4'hF = empty slot
- digitos_valid  output  1  one-cycle pulse; digitos_value already holds the new key in that cycle

Behaviour:
- Reset, and any cycle with teclado_en=0:
  - lin=4'b1111, digitos_value=all 1s, digitos_valid=0.
  - FSM goes to SCAN with row=0; all counters are zero.
  - Reset takes effect asynchronously at any point, including mid-debounce or mid-EMIT.
- Key map, [row][col] with col index 0 = LSB:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
  - Codes: digits -> 4'h0..4'h9, `*` -> 4'hA, `#` -> 4'hB.
  - Letters A-D are debounced and released normally but never emitted.
- FSM states: SCAN, DEBOUNCE, EMIT, RELEASE.
- SCAN:
  - lin = ~(1<<row).
  - After SETTLE_CYCLES cycles on a row, sample col.
  - Exactly one bit low -> latch row/col, go to DEBOUNCE (row stays driven).
  - No bit low, or two or more bits low -> row=(row+1) mod 4 and restart the settle count.
  - Lowest-numbered row with a valid single hit wins.
- DEBOUNCE:
  - Count consecutive cycles where col equals the latched pattern.
  - Any mismatch -> back to SCAN on the next row.
  - Count reaches DEBOUNCE_CYCLES -> EMIT for a numeric, `*` or `#` key; RELEASE for a letter key.
- EMIT (exactly 1 cycle):
  - digitos_valid=1.
  - digitos_value = {old digits[18:0], code}, registered so it changes in the same cycle valid rises. The 20th-oldest digit is discarded (wrap-around).
  - Next state: RELEASE.
  - If code is 4'hA or 4'hB, digitos_value becomes all 1s on the following cycle.
- RELEASE:
  - Keep driving the latched row.
  - Wait for col==4'b1111 for DEBOUNCE_CYCLES consecutive cycles; any low bit resets the count.
  - Then go to SCAN with row=0. A held key therefore emits exactly once.
- Timeout:
  - Counter increments every enabled cycle while digitos_value != all 1s.
  - It is zeroed in the EMIT cycle and whenever the buffer is empty.
  - On reaching TIMEOUT_CYCLES: buffer = all 1s, counter = 0, no valid pulse.
  - If timeout and EMIT coincide, EMIT wins: the buffer holds the shifted value and the counter restarts.
- digitos_valid is never high in two consecutive cycles.
- Latency, stable press to valid: (SETTLE_CYCLES to 4*SETTLE_CYCLES scan) + DEBOUNCE_CYCLES + 1 cycle.

Test Plan:
- Reset, teclado_en=1, press `5` (row1/col1 low while lin=4'b1101), hold 20 cycles -> exactly one valid pulse; digitos_value = 80'hFFFF...FFF5; lin=4'b1111 after reset.
- Press 1,2,3,4,5,6,7,8 each with release, then `*` -> valid 9 times. At the `*` pulse the low 36 bits = 36'h12345678A. The next cycle digitos_value = all 1s.
- Press `1` 21 times -> after 20 presses all 80 bits = 4'h1 repeated. The 21st press keeps all 20 digits = 1 (oldest dropped), with valid for every press.
- Bounce: col glitches low for 2 cycles (< DEBOUNCE_CYCLES=4) -> no valid and buffer unchanged. Press `C` held stable -> no valid, and the FSM reaches RELEASE.
- Press `9`, then idle TIMEOUT_CYCLES cycles -> buffer returns to all 1s with no valid pulse. Pressing `9` one cycle before timeout -> buffer = ...F99, counter restarts.
- Drop teclado_en mid-DEBOUNCE, and separately assert rst mid-EMIT -> next cycle lin=4'b1111, buffer all 1s, valid=0. Re-enable and press `0` -> 80'hFFFF...FFF0.
